// File: rtl/uart_rx_frame.sv
// UART receive engine: 2-flop synchroniser, oversampled 3-point majority vote,
// parity and stop-bit checking, one-cycle strobes for each finished frame.
module uart_rx_frame #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stop_Err
);

  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_W-1:0] P_MIN    = PRESCALE_W'(4);
  localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);
  localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  state;
  logic                    rx_s1;
  logic                    rx_s;
  logic [PRESCALE_W-1:0]   edge_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [2:0]              smp;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    par_fail;

  logic [PRESCALE_W-1:0]   p_eff;
  logic [PRESCALE_W-1:0]   mid;
  logic [PRESCALE_W-1:0]   last_edge;
  logic                    sample_pt;
  logic                    bit_end;
  logic [2:0]              smp_nxt;
  logic                    vote;
  logic                    par_exp;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_s1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_s1 <= RX_IN;
      rx_s  <= rx_s1;
    end
  end

  // Bit timing and vote; the current sample is folded in so tiny ratios still see 3 samples.
  always_comb begin
    p_eff     = (Prescale < P_MIN) ? P_MIN : Prescale;
    mid       = p_eff >> 1;
    last_edge = p_eff - ONE;
    sample_pt = (edge_cnt == (mid - ONE)) || (edge_cnt == mid) || (edge_cnt == (mid + ONE));
    bit_end   = (edge_cnt >= last_edge);
    smp_nxt   = sample_pt ? {smp[1:0], rx_s} : smp;
    vote      = (smp_nxt[0] & smp_nxt[1]) | (smp_nxt[0] & smp_nxt[2]) | (smp_nxt[1] & smp_nxt[2]);
    par_exp   = (^shreg) ^ par_typ_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      smp        <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_fail   <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stop_Err   <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stop_Err   <= 1'b0;
      smp        <= smp_nxt;

      if (state == IDLE) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= bit_end ? '0 : (edge_cnt + ONE);
      end

      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          par_fail <= 1'b0;
          if (!rx_s) begin
            state <= START;
          end
        end

        START: begin
          if (bit_end) begin
            if (vote) begin
              state <= IDLE;
            end else begin
              state     <= DATA;
              bit_cnt   <= '0;
              par_fail  <= 1'b0;
              par_en_q  <= PAR_EN;
              par_typ_q <= PAR_TYP;
            end
          end
        end

        DATA: begin
          if (bit_end) begin
            shreg <= {vote, shreg[DATA_WIDTH-1:1]};
            if (bit_cnt == LAST_BIT) begin
              state <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            if (vote != par_exp) begin
              par_fail <= 1'b1;
              Par_Err  <= 1'b1;
            end
            state <= STOP;
          end
        end

        STOP: begin
          if (bit_end) begin
            if (!vote) begin
              Stop_Err <= 1'b1;
            end else if (!par_fail) begin
              Data_Valid <= 1'b1;
              P_DATA     <= shreg;
            end
            // A good stop followed by a low line is the next start bit already;
            // entering START directly keeps back-to-back frames on their own timing.
            state <= (vote && !rx_s) ? START : IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: line-level frame generator with a
// frame-level expectation model, per-cycle output compare, directed and random frames.
module tb_uart_rx_frame;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 6;

  logic          CLK      = 1'b0;
  logic          RST      = 1'b1;
  logic          RX_IN    = 1'b1;
  logic [PW-1:0] Prescale = PW'(8);
  logic          PAR_EN   = 1'b0;
  logic          PAR_TYP  = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          Par_Err;
  logic          Stop_Err;

  uart_rx_frame #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .Prescale  (Prescale),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .Par_Err   (Par_Err),
    .Stop_Err  (Stop_Err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    int         p;
    int         nbits;
    bit         pe;
    bit         se;
    bit         dv;
  } frame_t;

  frame_t     frames[$];
  bit         line_q[$];
  int         mark_q[$];
  bit         dv_at[int];
  bit         pe_at[int];
  bit         se_at[int];
  logic [7:0] dv_data[int];

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  bit         chk_en = 1'b0;
  logic [7:0] model_pdata = 8'h00;
  int         dv_cnt = 0;
  int         pe_cnt = 0;
  int         se_cnt = 0;
  int         dv_cyc[$];
  int         dv_last = -1;
  int         last_t0 = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Expected strobes for a frame whose start bit first reaches sync stage 1 at edge t0.
  task automatic schedule(input int idx, input int t0);
    frame_t f;
    int     t_end;
    f       = frames[idx];
    t_end   = t0 + f.nbits * f.p + 2;
    last_t0 = t0;
    if (f.pe) pe_at[t0 + 10 * f.p + 2] = 1'b1;
    if (f.se) begin
      se_at[t_end] = 1'b1;
    end else if (f.dv) begin
      dv_at[t_end]   = 1'b1;
      dv_data[t_end] = f.data;
    end
  endtask

  // Compare outputs against the model, then drive the next line element.
  always @(negedge CLK) begin
    int mark;
    if (chk_en) begin
      if (!RST) begin
        model_pdata = 8'h00;
        chk("rst_data_valid", 32'(Data_Valid), 32'd0);
        chk("rst_par_err",    32'(Par_Err),    32'd0);
        chk("rst_stop_err",   32'(Stop_Err),   32'd0);
        chk("rst_p_data",     32'(P_DATA),     32'd0);
      end else begin
        if (dv_at.exists(cyc)) model_pdata = dv_data[cyc];
        chk("data_valid", 32'(Data_Valid), 32'(dv_at.exists(cyc)));
        chk("par_err",    32'(Par_Err),    32'(pe_at.exists(cyc)));
        chk("stop_err",   32'(Stop_Err),   32'(se_at.exists(cyc)));
        chk("p_data",     32'(P_DATA),     32'(model_pdata));
      end
      if (Data_Valid === 1'b1) begin
        dv_cnt++;
        dv_last = cyc;
        dv_cyc.push_back(cyc);
      end
      if (Par_Err === 1'b1) pe_cnt++;
      if (Stop_Err === 1'b1) se_cnt++;
    end
    if (line_q.size() > 0) begin
      RX_IN = line_q.pop_front();
      mark  = mark_q.pop_front();
      if (mark >= 0) schedule(mark, cyc + 1);
    end else begin
      RX_IN = 1'b1;
    end
  end

  // Queue one frame (P line cycles per bit) plus an idle gap; glitch flips one line cycle.
  task automatic send(input logic [7:0] data, input bit par_bit, input bit stop,
                      input int glitch, input int gap);
    frame_t f;
    bit     bits[$];
    int     p;
    int     k;
    p       = int'(Prescale);
    f.data  = data;
    f.p     = p;
    f.nbits = PAR_EN ? 11 : 10;
    f.pe    = PAR_EN && (par_bit != ((^data) ^ PAR_TYP));
    f.se    = !stop;
    f.dv    = stop && !f.pe;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (PAR_EN) bits.push_back(par_bit);
    bits.push_back(stop);
    for (int b = 0; b < bits.size(); b++) begin
      for (int e = 0; e < p; e++) begin
        k = b * p + e;
        line_q.push_back((k == glitch) ? ~bits[b] : bits[b]);
        mark_q.push_back((k == 0) ? frames.size() : -1);
      end
    end
    frames.push_back(f);
    for (int g = 0; g < gap; g++) begin
      line_q.push_back(1'b1);
      mark_q.push_back(-1);
    end
  endtask

  task automatic drain();
    int g = 0;
    while (line_q.size() > 0 && g < 40000) begin
      @(posedge CLK);
      g++;
    end
    chk("drain_timeout", 32'(line_q.size()), 32'd0);
    repeat (int'(Prescale) + 6) @(posedge CLK);
    #2;
  endtask

  task automatic clr_cnt();
    dv_cnt = 0;
    pe_cnt = 0;
    se_cnt = 0;
    dv_last = -1;
    dv_cyc.delete();
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    line_q.delete();
    mark_q.delete();
    dv_at.delete();
    pe_at.delete();
    se_at.delete();
    dv_data.delete();
    RX_IN = 1'b1;
    repeat (cycles) @(posedge CLK);
    #2;
    RST = 1'b1;
  endtask

  initial begin : watchdog
    #800000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : main
    logic [7:0] d;
    bit         good_par;
    bit         stop;
    int         p;
    int         gap;
    int         gl;
    int         g;

    #1 RST = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;

    // P=8, no parity, 0xA5
    Prescale = PW'(8); PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clr_cnt();
    send(8'hA5, 1'b0, 1'b1, -1, 4);
    drain();
    chk("t1_latency", 32'(dv_last - last_t0), 32'd82);
    chk("t1_dv_count", 32'(dv_cnt), 32'd1);
    chk("t1_p_data", 32'(P_DATA), 32'hA5);
    chk("t1_err_count", 32'(pe_cnt + se_cnt), 32'd0);

    // P=16, even parity: good then bad parity on 0x3C
    Prescale = PW'(16); PAR_EN = 1'b1; PAR_TYP = 1'b0;
    clr_cnt();
    send(8'h3C, 1'b0, 1'b1, -1, 16);
    drain();
    chk("t2_latency", 32'(dv_last - last_t0), 32'd178);
    chk("t2_p_data", 32'(P_DATA), 32'h3C);
    send(8'h3C, 1'b1, 1'b1, -1, 16);
    drain();
    chk("t2_pe_count", 32'(pe_cnt), 32'd1);
    chk("t2_dv_count", 32'(dv_cnt), 32'd1);
    chk("t2_p_data_held", 32'(P_DATA), 32'h3C);

    // P=32, odd parity: 0x01 good, then 0x7F with a low stop bit
    Prescale = PW'(32); PAR_EN = 1'b1; PAR_TYP = 1'b1;
    clr_cnt();
    send(8'h01, 1'b0, 1'b1, -1, 8);
    drain();
    chk("t3_latency", 32'(dv_last - last_t0), 32'd354);
    chk("t3_p_data", 32'(P_DATA), 32'h01);
    send(8'h7F, 1'b0, 1'b0, -1, 8);
    drain();
    chk("t3_se_count", 32'(se_cnt), 32'd1);
    chk("t3_dv_count", 32'(dv_cnt), 32'd1);
    chk("t3_pe_count", 32'(pe_cnt), 32'd0);
    chk("t3_p_data_held", 32'(P_DATA), 32'h01);

    // P=8, 3-cycle false start, then a frame exactly as soon as the FSM must be idle again
    Prescale = PW'(8); PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clr_cnt();
    for (int i = 0; i < 9; i++) begin
      line_q.push_back(i >= 3);
      mark_q.push_back(-1);
    end
    send(8'h55, 1'b0, 1'b1, -1, 4);
    drain();
    chk("t4_dv_count", 32'(dv_cnt), 32'd1);
    chk("t4_latency", 32'(dv_last - last_t0), 32'd82);
    chk("t4_p_data", 32'(P_DATA), 32'h55);
    chk("t4_err_count", 32'(pe_cnt + se_cnt), 32'd0);

    // P=16, one-cycle glitch on the middle sample of data bit 3 of 0x00
    Prescale = PW'(16);
    clr_cnt();
    send(8'h00, 1'b0, 1'b1, 1 + 4 * 16 + 8, 4);
    drain();
    chk("t5_dv_count", 32'(dv_cnt), 32'd1);
    chk("t5_p_data", 32'(P_DATA), 32'h00);

    // P=8, back-to-back 0x12, 0x34, then reset in the middle of a third frame
    Prescale = PW'(8);
    clr_cnt();
    send(8'h12, 1'b0, 1'b1, -1, 0);
    send(8'h34, 1'b0, 1'b1, -1, 0);
    send(8'h56, 1'b0, 1'b1, -1, 0);
    g = 0;
    while (line_q.size() > 40 && g < 1000) begin
      @(posedge CLK);
      g++;
    end
    chk("t6_p_data_pre_reset", 32'(P_DATA), 32'h34);
    apply_reset(5);
    repeat (200) @(posedge CLK);
    #2;
    chk("t6_dv_count", 32'(dv_cnt), 32'd2);
    if (dv_cyc.size() == 2) chk("t6_dv_spacing", 32'(dv_cyc[1] - dv_cyc[0]), 32'd80);
    chk("t6_p_data_after_reset", 32'(P_DATA), 32'h00);
    chk("t6_err_count", 32'(pe_cnt + se_cnt), 32'd0);

    // Randomised frames: ratio, parity mode, data, parity/stop faults, glitches, gaps
    for (int blk = 0; blk < 8; blk++) begin
      p        = 8 << $urandom_range(0, 2);
      Prescale = PW'(p);
      PAR_EN   = 1'($urandom_range(0, 1));
      PAR_TYP  = 1'($urandom_range(0, 1));
      for (int f = 0; f < 5; f++) begin
        d        = 8'($urandom);
        good_par = (^d) ^ PAR_TYP;
        stop     = ($urandom_range(0, 5) != 0);
        gap      = stop ? int'($urandom_range(0, 2 * p)) : int'($urandom_range(1, 2 * p));
        gl       = -1;
        if ($urandom_range(0, 2) == 0) gl = int'($urandom_range(1, (PAR_EN ? 11 : 10) * p - 1));
        send(d, ($urandom_range(0, 3) == 0) ? ~good_par : good_par, stop, gl, gap);
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
